// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 LSB-first UART serializer; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx_fifo #(
  parameter int BAUD_DIV = 1252,
  parameter int ADDR_W   = 3
) (
  input  logic            clock,
  input  logic            nrst,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic [ADDR_W:0] fifo_count
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [2:0]        r_state;
  logic [BW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
`endif
  logic              w_full;
  logic              w_empty;
  logic              w_wrap;
  logic              w_pop;
  logic              w_push;
  logic              w_line;

  assign w_full     = r_count == DEPTH;
  assign w_empty    = r_count == '0;
  assign w_wrap     = r_baud == BAUD_LAST;
  // The serializer pops when idle, or at the last stop-bit clock to chain frames with no gap
  assign w_pop      = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_wrap));
  // A simultaneous pop frees a slot, so a full FIFO still accepts on that edge
  assign w_push     = tx_valid && (!w_full || w_pop);
  assign tx_ready   = !w_full;
  assign tx_busy    = r_state != S_IDLE;
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign w_line     = (r_state == S_START) ? 1'b0 :
                      (r_state == S_DATA)  ? r_shift[0] :
`ifdef UART_TX_PARITY_EN
                      (r_state == S_PARITY) ? r_par :
`endif
                      1'b1;

  // FIFO storage; data needs no reset since occupancy guards every read
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end

  // Serializer FSM: baud counter runs in every non-idle state, bits advance only on wrap
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_baud <= (r_state == S_IDLE || w_wrap) ? '0 : r_baud + 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_state <= S_START;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^r_mem[r_rptr];
`endif
      end else if (w_wrap) begin
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_bit   <= '0;
          end
          S_DATA: begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
            r_state <= (r_bit == 3'd7) ? S_AFTER_DATA : S_DATA;
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: r_state <= S_STOP;
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Line driver registered from the current state so tx never glitches
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) r_tx <= 1'b1;
    else r_tx <= w_line;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-level model of uart_tx_fifo checked every cycle, plus directed literal checks
module tb_uart_tx_fifo;
  localparam int BD = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
  localparam bit PAR = 1'b1;
  localparam logic [15:0] A5_BITS = 16'b010_1001_0101;
  localparam int ONE_FRAME = 44;
`else
  localparam int FL = 10;
  localparam bit PAR = 1'b0;
  localparam logic [15:0] A5_BITS = 16'b01_0100_1011;
  localparam int ONE_FRAME = 40;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [3:0] fifo_count;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_pos = -1;
  logic       m_tx = 1'b1;
  int         m_acc_n = 0;
  int         m_old;
  logic       m_pop;
  logic       m_acc;

  logic cap[$];
  logic bcap[$];

  uart_tx_fifo #(.BAUD_DIV(BD), .ADDR_W(3)) dut (
    .clock(clk), .nrst(nrst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Model: a frame occupies FL*BD clocks; the line shows each frame bit one clock after the frame position
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_q.delete();
      m_pos = -1;
      m_tx = 1'b1;
    end else begin
      m_old = m_pos;
      m_tx = (m_old >= 0) ? frame_bit(m_cur, m_old / BD) : 1'b1;
      m_pop = (m_q.size() != 0) && (m_old < 0 || m_old == FL*BD - 1);
      m_acc = tx_valid && (m_q.size() < DEPTH || m_pop);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end else if (m_old == FL*BD - 1) m_pos = -1;
      else if (m_old >= 0) m_pos++;
      if (m_acc) begin
        m_q.push_back(tx_data);
        m_acc_n++;
      end
    end
  end

  always @(negedge clk) begin
    cap.push_back(tx);
    bcap.push_back(tx_busy);
    if (nrst) begin
      chk("model_tx", 32'(tx), 32'(m_tx));
      chk("model_busy", 32'(tx_busy), 32'(m_pos >= 0));
      chk("model_count", 32'(fifo_count), 32'(m_q.size()));
      chk("model_ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
    end
  end

  function automatic void decode(input int s, output bq_t q, output int ferr);
    int i = s;
    q = {};
    ferr = 0;
    while (i + FL*BD <= cap.size()) begin
      if (cap[i] == 1'b0) begin
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = cap[i + (k+1)*BD + BD/2];
        if (cap[i + BD/2] !== 1'b0) ferr++;
        if (cap[i + (FL-1)*BD + BD/2] !== 1'b1) ferr++;
        if (PAR && cap[i + 9*BD + BD/2] !== ^b) ferr++;
        q.push_back(b);
        i += FL*BD;
      end else i++;
    end
  endfunction

  function automatic logic [15:0] frame_bits(input int s);
    logic [15:0] r = '0;
    for (int i = s; i + FL*BD <= cap.size(); i++) begin
      if (cap[i] == 1'b0) begin
        for (int k = 0; k < FL; k++) r = {r[14:0], cap[i + k*BD + BD/2]};
        return r;
      end
    end
    return 16'hFFFF;
  endfunction

  function automatic int busy_run(input int s);
    int run = 0;
    int best = 0;
    for (int i = s; i < bcap.size(); i++) begin
      run = bcap[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  task automatic check_rx(input string nm, input int s, input bq_t e);
    bq_t q;
    int ferr;
    decode(s, q, ferr);
    chk({nm, "_framing"}, 32'(ferr), 32'd0);
    chk({nm, "_nbytes"}, 32'(q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < q.size(); i++) chk({nm, "_byte"}, 32'(q[i]), 32'(e[i]));
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int s;
    int a0;
    bq_t e;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    s = cap.size();
    push(8'hA5);
    chk("lat_count1", 32'(fifo_count), 32'd1);
    chk("lat_busy_n", 32'(tx_busy), 32'd0);
    @(negedge clk);
    chk("lat_busy_n1", 32'(tx_busy), 32'd1);
    chk("lat_tx_n1", 32'(tx), 32'd1);
    @(negedge clk);
    chk("lat_tx_n2", 32'(tx), 32'd0);
    repeat (60) @(negedge clk);
    chk("a5_bits", 32'(frame_bits(s)), 32'(A5_BITS));
    chk("a5_busy_len", 32'(busy_run(s)), 32'(ONE_FRAME));
    e = {8'hA5};
    check_rx("a5", s, e);

    s = cap.size();
    push(8'h00);
    push(8'hFF);
    repeat (110) @(negedge clk);
    chk("b2b_busy_len", 32'(busy_run(s)), 32'(2*ONE_FRAME));
    e = {8'h00, 8'hFF};
    check_rx("b2b", s, e);

    s = cap.size();
    push(8'hEE);
    repeat (2) @(negedge clk);
    for (int d = 1; d <= 10; d++) push(8'(d));
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_ready", 32'(tx_ready), 32'd0);
    repeat (460) @(negedge clk);
    chk("ovf_drained", 32'(fifo_count), 32'd0);
    e = {8'hEE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_rx("ovf", s, e);

    s = cap.size();
    push(8'hEE);
    repeat (2) @(negedge clk);
    for (int d = 1; d <= 8; d++) push(8'(d));
    chk("full_count", 32'(fifo_count), 32'd8);
    a0 = m_acc_n;
    tx_valid = 1'b1;
    tx_data = 8'h99;
    for (int c = 0; c < 200 && m_acc_n == a0; c++) @(negedge clk);
    tx_valid = 1'b0;
    chk("full_pp_accepted", 32'(m_acc_n - a0), 32'd1);
    chk("full_pp_count", 32'(fifo_count), 32'd8);
    repeat (500) @(negedge clk);
    e = {8'hEE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
    check_rx("full_pp", s, e);

    push(8'h3C);
    repeat (15) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    s = cap.size();
    push(8'h5A);
    repeat (60) @(negedge clk);
    e = {8'h5A};
    check_rx("post_rst", s, e);

`ifdef UART_TX_PARITY_EN
    s = cap.size();
    push(8'h07);
    repeat (60) @(negedge clk);
    chk("par_07_bit", 32'(frame_bits(s) >> 1) & 32'd1, 32'd1);
    chk("par_a5_bit", 32'(A5_BITS >> 1) & 32'd1, 32'(frame_bits(0) >> 1) & 32'd1);
    chk("par_07_busy_len", 32'(busy_run(s)), 32'd44);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
